// File: rtl/pe_operand_bus_unit.sv
// pe_operand_bus_unit: PE register file, operand fetch and a req/ack memory-bus bridge with timeout.
// Optional macro PE_BYPASS_EN forwards same-edge writeback data into an operand fetch.
module pe_operand_bus_unit #(
  parameter int unsigned NREGS   = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic        rd_write,
  input  logic [31:0] wb_data,
  input  logic        reg_select,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  output logic [31:0] a_data,
  output logic [31:0] b_data,
  output logic        data_ready,
  output logic        mem_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        busy,
  output logic        bus_err
);
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_regs [NREGS];
  logic [TO_W-1:0] r_cnt;
  logic            r_op_write;
  logic [DW-1:0]   r_a_data, r_b_data, r_bus_addr, r_bus_wdata;
  logic            r_data_ready, r_mem_ack, r_bus_req, r_bus_we, r_busy, r_bus_err;

  logic [TO_W-1:0] w_cnt_inc, w_cnt_d;
  logic            w_timeout;
  logic [DW-1:0]   w_rs1_val, w_rs2_val;
  logic            w_op_write_d;
  logic [DW-1:0]   w_a_d, w_b_d, w_addr_d, w_wdata_d;
  logic            w_ready_d, w_ack_d, w_req_d, w_we_d, w_busy_d, w_err_d;

  assign w_cnt_inc = r_cnt + TO_W'(1);
  assign w_timeout = (w_cnt_inc == TO_W'(TIMEOUT));

  // Register file; x0 is never written so it always reads zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[AW'(i)] <= '0;
    end else if (rd_write && (rd_addr != '0)) begin
      r_regs[rd_addr] <= wb_data;
    end
  end

  // Operand read ports, optionally forwarding the writeback on the same edge
  always_comb begin
    w_rs1_val = (rs1_addr == '0) ? '0 : r_regs[rs1_addr];
    w_rs2_val = (rs2_addr == '0) ? '0 : r_regs[rs2_addr];
`ifdef PE_BYPASS_EN
    if (rd_write && (rd_addr != '0) && (rd_addr == rs1_addr)) w_rs1_val = wb_data;
    if (rd_write && (rd_addr != '0) && (rd_addr == rs2_addr)) w_rs2_val = wb_data;
`else
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (mem_read || mem_write) w_state_nxt = S_REQ;
      S_REQ:   w_state_nxt = S_WAIT;
      S_WAIT:  if (bus_ack || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; a load response overrides a colliding fetch on b_data
  always_comb begin
    w_cnt_d      = r_cnt;
    w_op_write_d = r_op_write;
    w_addr_d     = r_bus_addr;
    w_wdata_d    = r_bus_wdata;
    w_err_d      = r_bus_err;
    w_a_d        = r_a_data;
    w_b_d        = r_b_data;
    w_ready_d    = 1'b0;
    w_ack_d      = 1'b0;
    w_req_d      = (w_state_nxt == S_REQ) || (w_state_nxt == S_WAIT);
    w_busy_d     = (w_state_nxt != S_IDLE);
    if (reg_select) begin
      w_a_d     = w_rs1_val;
      w_b_d     = w_rs2_val;
      w_ready_d = 1'b1;
    end
    case (r_state)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          w_addr_d     = mem_address;
          w_wdata_d    = wb_data;
          w_op_write_d = mem_write && !mem_read;
          w_cnt_d      = '0;
          if (mem_read && mem_write) w_err_d = 1'b1;
        end
      end
      S_WAIT: begin
        w_cnt_d = w_cnt_inc;
        if (bus_ack || w_timeout) begin
          w_cnt_d = '0;
          w_ack_d = 1'b1;
          if (!bus_ack) w_err_d = 1'b1;
          if (!r_op_write) begin
            w_b_d     = bus_ack ? bus_rdata : '0;
            w_ready_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    w_we_d = w_req_d && w_op_write_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_op_write   <= 1'b0;
      r_a_data     <= '0;
      r_b_data     <= '0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_data_ready <= 1'b0;
      r_mem_ack    <= 1'b0;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_busy       <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_d;
      r_op_write   <= w_op_write_d;
      r_a_data     <= w_a_d;
      r_b_data     <= w_b_d;
      r_bus_addr   <= w_addr_d;
      r_bus_wdata  <= w_wdata_d;
      r_data_ready <= w_ready_d;
      r_mem_ack    <= w_ack_d;
      r_bus_req    <= w_req_d;
      r_bus_we     <= w_we_d;
      r_busy       <= w_busy_d;
      r_bus_err    <= w_err_d;
    end
  end

  assign a_data     = r_a_data;
  assign b_data     = r_b_data;
  assign data_ready = r_data_ready;
  assign mem_ack    = r_mem_ack;
  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign busy       = r_busy;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_pe_operand_bus_unit.sv
// tb_pe_operand_bus_unit: directed and randomized checks against a transaction-timeline reference model.
`timescale 1ns/1ps
module tb_pe_operand_bus_unit;
  localparam int unsigned TB_TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rd_write, reg_select, mem_read, mem_write, bus_ack;
  logic [31:0] wb_data, mem_address, bus_rdata;
  logic [31:0] a_data, b_data, bus_addr, bus_wdata;
  logic        data_ready, mem_ack, bus_req, bus_we, busy, bus_err;

  pe_operand_bus_unit #(.NREGS(32), .TIMEOUT(TB_TO), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .rd_write(rd_write),
    .wb_data(wb_data), .reg_select(reg_select), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .a_data(a_data), .b_data(b_data), .data_ready(data_ready),
    .mem_ack(mem_ack), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural registers plus a timeline of the current bus transaction
  logic [31:0] m_regs [32];
  int          e;
  int          t_acc;
  bit          act, resolved, m_wr;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] x_a, x_b;
  bit          x_ready, x_ack, x_req, x_we, x_busy, x_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    rs1_addr = '0; rs2_addr = '0; rd_addr = '0; rd_write = 1'b0; wb_data = '0;
    reg_select = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
    bus_ack = 1'b0; bus_rdata = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    act = 0; resolved = 0; m_wr = 0; m_addr = '0; m_wdata = '0; t_acc = 0;
    x_a = '0; x_b = '0; x_ready = 0; x_ack = 0; x_req = 0; x_we = 0; x_busy = 0; x_err = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : m_regs[a];
`ifdef PE_BYPASS_EN
    if (rd_write && (rd_addr != 5'd0) && (rd_addr == a)) v = wb_data;
`endif
    return v;
  endfunction

  // One clock edge of the model, using the inputs present at that edge
  task automatic model_edge();
    int k;
    x_ready = 0;
    x_ack   = 0;
    if (reg_select) begin
      x_a = model_read(rs1_addr);
      x_b = model_read(rs2_addr);
      x_ready = 1;
    end
    if (!act) begin
      if (mem_read || mem_write) begin
        act = 1; resolved = 0; t_acc = e;
        m_wr = mem_write && !mem_read;
        m_addr = mem_address; m_wdata = wb_data;
        if (mem_read && mem_write) x_err = 1;
      end
    end else if (!resolved) begin
      k = e - t_acc - 1;
      if (k >= 1 && (bus_ack || k == int'(TB_TO))) begin
        resolved = 1;
        x_ack = 1;
        if (!bus_ack) x_err = 1;
        if (!m_wr) begin
          x_b = bus_ack ? bus_rdata : 32'd0;
          x_ready = 1;
        end
      end
    end else begin
      act = 0;
    end
    if (rd_write && rd_addr != 5'd0) m_regs[rd_addr] = wb_data;
    x_req  = act && !resolved;
    x_busy = act;
    x_we   = x_req && m_wr;
    e++;
  endtask

  task automatic compare_all();
    check("a_data", a_data, x_a);
    check("b_data", b_data, x_b);
    check("data_ready", 32'(data_ready), 32'(x_ready));
    check("mem_ack", 32'(mem_ack), 32'(x_ack));
    check("bus_req", 32'(bus_req), 32'(x_req));
    check("busy", 32'(busy), 32'(x_busy));
    check("bus_err", 32'(bus_err), 32'(x_err));
    if (x_req) begin
      check("bus_we", 32'(bus_we), 32'(x_we));
      check("bus_addr", bus_addr, m_addr);
      if (x_we) check("bus_wdata", bus_wdata, m_wdata);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Asserted away from the clock edge; outputs must clear without waiting for an edge
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_bus_req", 32'(bus_req), 32'd0);
    compare_all();
    set_idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int ack_delay,
                         output bit seen_we, output logic [31:0] seen_addr,
                         output logic [31:0] seen_wdata);
    int cnt;
    bit done;
    cnt = 0; done = 0;
    seen_we = 0; seen_addr = '0; seen_wdata = '0;
    mem_read = rd; mem_write = wr; mem_address = addr; wb_data = wdata;
    bus_rdata = rdata; bus_ack = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      if (mem_ack) begin
        done = 1;
      end else begin
        if (bus_req) begin
          cnt++;
          seen_we = bus_we; seen_addr = bus_addr; seen_wdata = bus_wdata;
        end else begin
          cnt = 0;
        end
        bus_ack = (cnt >= ack_delay + 1);
      end
    end
    check("txn_complete", 32'(done), 32'd1);
  endtask

  bit          s_we;
  logic [31:0] s_addr, s_wdata, exp_v;

  initial begin
    set_idle();
    model_reset();
    e = 0;
    #2;
    apply_reset();

    // Writeback x5 then dependent fetch one cycle later
    rd_write = 1'b1; rd_addr = 5'd5; wb_data = 32'hDEADBEEF;
    step();
    rd_write = 1'b0; reg_select = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd0;
    step();
    check("fetch_x5", a_data, 32'hDEADBEEF);
    check("fetch_x0_b", b_data, 32'h0);
    check("fetch_ready", 32'(data_ready), 32'd1);
    reg_select = 1'b0;
    step();
    check("ready_one_pulse", 32'(data_ready), 32'd0);

    // Write to x0 is discarded
    rd_write = 1'b1; rd_addr = 5'd0; wb_data = 32'h1;
    step();
    rd_write = 1'b0; reg_select = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd5;
    step();
    check("x0_reads_zero", a_data, 32'h0);
    set_idle();
    step();

    // Load with a delayed bus_ack
    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 32'h1234, 2, s_we, s_addr, s_wdata);
    check("load_b_data", b_data, 32'h1234);
    check("load_ready", 32'(data_ready), 32'd1);
    check("load_we", 32'(s_we), 32'd0);
    check("load_addr", s_addr, 32'h100);
    set_idle();
    step();

    // Store
    run_txn(1'b0, 1'b1, 32'h200, 32'hCAFE, 32'h9999, 1, s_we, s_addr, s_wdata);
    check("store_we", 32'(s_we), 32'd1);
    check("store_wdata", s_wdata, 32'hCAFE);
    check("store_no_ready", 32'(data_ready), 32'd0);
    check("store_no_err", 32'(bus_err), 32'd0);
    set_idle();
    step();

    // Same-edge write and fetch of x7
    rd_write = 1'b1; rd_addr = 5'd7; wb_data = 32'h11;
    step();
    wb_data = 32'h55; reg_select = 1'b1; rs1_addr = 5'd7;
    step();
`ifdef PE_BYPASS_EN
    exp_v = 32'h55;
`else
    exp_v = 32'h11;
`endif
    check("same_edge_x7", a_data, exp_v);
    set_idle();
    step();

    // Timeout: bus_ack never arrives
    run_txn(1'b1, 1'b0, 32'h300, 32'h0, 32'hFFFF, 1000, s_we, s_addr, s_wdata);
    check("timeout_err", 32'(bus_err), 32'd1);
    check("timeout_b_zero", b_data, 32'h0);
    set_idle();
    step();

    // Reset in the middle of WAIT abandons the transaction
    mem_read = 1'b1; mem_address = 32'h40;
    step();
    step();
    #3;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_ack_after_reset", 32'(mem_ack), 32'd0);
    end

    // Read and write together: performed as a read, error flagged
    run_txn(1'b1, 1'b1, 32'h500, 32'hAAAA, 32'h77, 0, s_we, s_addr, s_wdata);
    check("both_is_read", 32'(s_we), 32'd0);
    check("both_err", 32'(bus_err), 32'd1);
    check("both_load_data", b_data, 32'h77);
    set_idle();
    step();

    // Randomized traffic after a fresh reset
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      rd_write    = ($urandom_range(0, 1) == 1);
      rd_addr     = 5'($urandom_range(0, 31));
      wb_data     = $urandom;
      reg_select  = ($urandom_range(0, 2) == 0);
      rs1_addr    = 5'($urandom_range(0, 31));
      rs2_addr    = 5'($urandom_range(0, 31));
      mem_read    = ($urandom_range(0, 5) == 0);
      mem_write   = ($urandom_range(0, 5) == 0) && (i > 400 || !mem_read);
      mem_address = $urandom;
      bus_ack     = ($urandom_range(0, 3) == 0);
      bus_rdata   = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
